// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and 27 MHz default cycle constants for the rPLL lock/reset controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } pll_ctrl_state_t;

    localparam int DEF_LOCK_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RESET_CYCLES    = 27;      // 1 us
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 270000;  // 10 ms
    localparam int DEF_LOCK_STABLE_CYCLES  = 2700;    // 100 us
    localparam int DEF_N_RST_STAGES        = 3;
    localparam int DEF_STAGE_GAP_CYCLES    = 16;
    localparam int DEF_RETRY_LIMIT         = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_sync_ff.sv
// Generic N-flop level synchronizer; latency STAGES cycles; no backpressure.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// rPLL reset/lock supervisor with staged downstream reset release; PLL_LOCK_LOSS_COUNT_EN builds the lock-loss counter.
// Latency: lock changes act LOCK_SYNC_STAGES+1 cycles after the pin; all outputs registered.
// Backpressure: none; lock is a level input, loss of lock always wins over a pending stage release.
module pll_lock_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_SYNC_STAGES    = DEF_LOCK_SYNC_STAGES,
    parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int N_RST_STAGES        = DEF_N_RST_STAGES,
    parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
    parameter int RETRY_LIMIT         = DEF_RETRY_LIMIT
) (
    input  logic                    in_clk_27mhz,
    input  logic                    in_rst_n,
    input  logic                    in_pll_lock,
    output logic                    out_pll_reset,
    output logic [N_RST_STAGES-1:0] out_rst_n,
    output logic                    out_ready,
    output logic                    out_fault,
    output logic [3:0]              out_retry_count,
    output logic [7:0]              out_lock_loss_count
);

    localparam int CNT_MAX = max_int(max_int(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES),
                                     max_int(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES));
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam int IW = (N_RST_STAGES > 1) ? $clog2(N_RST_STAGES) : 1;

    localparam logic [CW-1:0] RST_LAST   = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_RST_STAGES - 1);
    localparam logic [3:0]    RETRY_LAST = 4'(RETRY_LIMIT - 1);

    pll_ctrl_state_t state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   tmo_cnt;  // survives STABLE so lock chatter cannot extend the timeout window
    logic [IW-1:0]   idx;
    logic            lock_s;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0]      loss_cnt;
`endif

    sync_ff #(.STAGES(LOCK_SYNC_STAGES)) u_lock_sync (
        .clk   (in_clk_27mhz),
        .rst_n (in_rst_n),
        .d     (in_pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge in_clk_27mhz or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= PLL_RST;
            cnt             <= '0;
            tmo_cnt         <= '0;
            idx             <= '0;
            out_pll_reset   <= 1'b1;
            out_rst_n       <= '0;
            out_ready       <= 1'b0;
            out_fault       <= 1'b0;
            out_retry_count <= '0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
            loss_cnt        <= '0;
`endif
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state         <= WAIT_LOCK;
                        cnt           <= '0;
                        tmo_cnt       <= '0;
                        out_pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        out_retry_count <= out_retry_count + 4'd1;
                        out_pll_reset   <= 1'b1;
                        cnt             <= '0;
                        if (out_retry_count == RETRY_LAST) begin
                            state     <= FAULT;
                            out_fault <= 1'b1;
                        end else begin
                            state <= PLL_RST;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        state         <= PLL_RST;
                        cnt           <= '0;
                        out_pll_reset <= 1'b1;
                        out_rst_n     <= '0;
                        out_ready     <= 1'b0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
                        if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
`endif
                    end else if (state == RELEASE) begin
                        // cnt is the down-counted gap to the next stage
                        if (cnt == '0) begin
                            out_rst_n[idx] <= 1'b1;
                            if (idx == IDX_LAST) begin
                                state           <= RUN;
                                out_ready       <= 1'b1;
                                out_retry_count <= '0;
                            end else begin
                                idx <= idx + IW'(1);
                                cnt <= GAP_LAST;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                FAULT: begin
                    out_pll_reset <= 1'b1;
                    out_rst_n     <= '0;
                    out_ready     <= 1'b0;
                    out_fault     <= 1'b1;
                end
                default: begin
                    state         <= PLL_RST;
                    cnt           <= '0;
                    out_pll_reset <= 1'b1;
                    out_rst_n     <= '0;
                    out_ready     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    assign out_lock_loss_count = loss_cnt;
`else
    assign out_lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Bench for pll_lock_reset_ctrl: directed lock scenarios then random lock traces against a timestamp-based model.
module tb_pll_lock_reset_ctrl;

    localparam int R = 4, TMO = 64, STB = 8, N = 3, GAP = 2, LIM = 2, SYNC = 2;
    localparam int P_RST = 0, P_WAIT = 1, P_QUAL = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       pll_reset;
    logic [2:0] rstn_o;
    logic       ready, fault;
    logic [3:0] retry;
    logic [7:0] losses;

    int n_cmp = 0, n_bad = 0;

    // model: phase, phase entry edge, edge number, per-phase tallies
    int   m_ph, m_t0, m_k, m_nolock, m_good, m_retries, m_losses;
    logic h1, h2;

    always #5 clk = ~clk;

    pll_lock_reset_ctrl #(
        .LOCK_SYNC_STAGES   (SYNC),
        .PLL_RESET_CYCLES   (R),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .LOCK_STABLE_CYCLES (STB),
        .N_RST_STAGES       (N),
        .STAGE_GAP_CYCLES   (GAP),
        .RETRY_LIMIT        (LIM)
    ) dut (
        .in_clk_27mhz       (clk),
        .in_rst_n           (rst_n),
        .in_pll_lock        (lock),
        .out_pll_reset      (pll_reset),
        .out_rst_n          (rstn_o),
        .out_ready          (ready),
        .out_fault          (fault),
        .out_retry_count    (retry),
        .out_lock_loss_count(losses)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rel_bits(input int e);
        int b;
        if (e < 1) return 0;
        b = (e - 1) / GAP + 1;
        return (b > N) ? N : b;
    endfunction

    function automatic logic [31:0] model_word();
        logic [2:0] rn;
        logic [7:0] lc;
        rn = 3'b000;
        if (m_ph == P_RUN) rn = 3'b111;
        else if (m_ph == P_REL) rn = 3'((1 << rel_bits(m_k - m_t0)) - 1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        lc = 8'(m_losses);
`else
        lc = 8'd0;
`endif
        return {14'd0, (m_ph == P_RST || m_ph == P_FAULT), rn, (m_ph == P_RUN),
                (m_ph == P_FAULT), 4'(m_retries), lc};
    endfunction

    function automatic logic [31:0] dut_word();
        return {14'd0, pll_reset, rstn_o, ready, fault, retry, losses};
    endfunction

    task automatic model_init();
        m_ph = P_RST; m_t0 = 0; m_k = 0; m_nolock = 0; m_good = 0;
        m_retries = 0; m_losses = 0; h1 = 1'b0; h2 = 1'b0;
    endtask

    task automatic model_edge(input logic ls);
        m_k++;
        case (m_ph)
            P_RST: if (m_k - m_t0 == R) begin m_ph = P_WAIT; m_nolock = 0; end
            P_WAIT: begin
                if (ls) begin
                    m_ph = P_QUAL; m_good = 0;
                end else begin
                    m_nolock++;
                    if (m_nolock == TMO) begin
                        m_retries++;
                        if (m_retries == LIM) m_ph = P_FAULT;
                        else begin m_ph = P_RST; m_t0 = m_k; end
                    end
                end
            end
            P_QUAL: begin
                if (!ls) m_ph = P_WAIT;
                else begin
                    m_good++;
                    if (m_good == STB) begin m_ph = P_REL; m_t0 = m_k; end
                end
            end
            P_REL, P_RUN: begin
                if (!ls) begin
                    if (m_losses < 255) m_losses++;
                    m_ph = P_RST; m_t0 = m_k;
                end else if (m_ph == P_REL && rel_bits(m_k - m_t0) == N) begin
                    m_ph = P_RUN; m_retries = 0;
                end
            end
            default: ;
        endcase
    endtask

    // lock seen by the controller at an edge is the pin value two edges earlier
    task automatic step(input logic l);
        lock = l;
        @(posedge clk);
        model_edge(h2);
        h2 = h1;
        h1 = l;
        #1;
        check("cyc", dut_word(), model_word());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lock  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vals", dut_word(), {14'd0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0});
        rst_n = 1'b1;
        model_init();
    endtask

    initial begin
        int hi, t1, t3, t7, len;
        logic rdy7, saw, reached, lv;
        logic [2:0] mx;

        // 1: lock 10 cycles after reset release, clean staged release
        do_reset();
        hi = int'(pll_reset);
        for (int i = 0; i < 10; i++) begin step(1'b0); hi += int'(pll_reset); end
        t1 = -1; t3 = -1; t7 = -1; rdy7 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (rstn_o == 3'b001 && t1 < 0) t1 = i;
            if (rstn_o == 3'b011 && t3 < 0) t3 = i;
            if (rstn_o == 3'b111 && t7 < 0) begin t7 = i; rdy7 = ready; end
        end
        check("s1_prst_len", hi, 4);
        check("s1_stage0_seen", (t1 >= 0), 1);
        check("s1_gap01", t3 - t1, GAP);
        check("s1_gap12", t7 - t3, GAP);
        check("s1_ready_w_111", rdy7, 1);

        // 2: lock never rises -> retries then sticky fault
        do_reset();
        saw = 1'b0;
        for (int i = 0; i < 160; i++) begin step(1'b0); if (retry == 4'd1) saw = 1'b1; end
        check("s2_retry1_seen", saw, 1);
        check("s2_retry", retry, 2);
        check("s2_fault", fault, 1);
        check("s2_prst", pll_reset, 1);
        for (int i = 0; i < 20; i++) step(1'b1);
        check("s2_fault_sticky", fault, 1);
        check("s2_rstn_held", rstn_o, 0);

        // 3: short lock pulse must not release; later long lock does
        do_reset();
        mx = 3'b000;
        for (int i = 0; i < 6; i++)  begin step(1'b0); mx |= rstn_o; end
        for (int i = 0; i < 5; i++)  begin step(1'b1); mx |= rstn_o; end
        for (int i = 0; i < 12; i++) begin step(1'b0); mx |= rstn_o; end
        check("s3_no_release", mx, 0);
        for (int i = 0; i < 30; i++) step(1'b1);
        check("s3_ready", ready, 1);
        check("s3_retry", retry, 0);

        // 4: lock loss in RUN
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (i == SYNC) begin
                check("s4_rstn_drop", rstn_o, 0);
                check("s4_ready_drop", ready, 0);
            end
            if (i >= SYNC) hi += int'(pll_reset);
        end
        check("s4_prst_len", hi, R);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        check("s4_loss_cnt", losses, 1);
`else
        check("s4_loss_cnt", losses, 0);
`endif

        // 5: lock drops right at RELEASE entry; loss lands with stage 1 release
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            step(1'b1);
            if (m_ph == P_REL) reached = 1'b1;
        end
        check("s5_reach_release", reached, 1);
        mx = 3'b000; saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            mx |= rstn_o;
            if (pll_reset) saw = 1'b1;
        end
        check("s5_only_stage0", mx, 3'b001);
        check("s5_restart", saw, 1);
        check("s5_rstn_low", rstn_o, 0);

        // 6: async reset during RELEASE
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            step(1'b1);
            if (m_ph == P_REL && rel_bits(m_k - m_t0) >= 1) reached = 1'b1;
        end
        check("s6_reach_release", reached, 1);
        #3 rst_n = 1'b0;
        #1;
        check("s6_async_vals", dut_word(), {14'd0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0});
        do_reset();

        // random lock traces
        for (int r = 0; r < 25; r++) begin
            if (m_ph == P_FAULT || $urandom_range(0, 3) == 0) do_reset();
            for (int s = 0; s < 6; s++) begin
                lv  = 1'($urandom_range(0, 1));
                len = lv ? $urandom_range(1, 40) : $urandom_range(1, 30);
                if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) step(lv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
